// File: rtl/eth_arb_mux_wrr.sv
// -----------------------------------------------------------------------------
// eth_arb_mux_wrr
//
// Weighted round-robin multiplexer for Ethernet frames (header + AXI-stream
// payload). S_COUNT source ports compete for one output. A granted port may
// keep the output for up to cfg_weight consecutive frames before the next
// requesting port (searching upward from the last winner, with wrap-around)
// takes over. Arbitration and header acceptance happen only between frames.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   s_eth_hdr_*                     per-port header handshake and fields
//   s_eth_payload_axis_*            per-port payload AXI-stream
//   cfg_weight                      per-port consecutive-frame quota (0 acts as 1)
//   m_eth_hdr_*                     registered output header
//   m_eth_payload_axis_*            output payload through a 2-entry skid buffer
//   busy                            high while a frame payload is in progress
//   grant_index                     current / last granted port
//   stat_frame_count                per-port completed-frame counters
//                                   (only with ETH_ARB_MUX_WRR_STATS_EN defined)
//
// Optional feature macro: ETH_ARB_MUX_WRR_STATS_EN
// -----------------------------------------------------------------------------
module eth_arb_mux_wrr #(
  parameter int S_COUNT      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter bit KEEP_ENABLE  = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1,
  parameter int WEIGHT_WIDTH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             rst,

  input  logic [S_COUNT-1:0]               s_eth_hdr_valid,
  output logic [S_COUNT-1:0]               s_eth_hdr_ready,
  input  logic [S_COUNT*48-1:0]            s_eth_dest_mac,
  input  logic [S_COUNT*48-1:0]            s_eth_src_mac,
  input  logic [S_COUNT*16-1:0]            s_eth_type,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_eth_payload_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_eth_payload_axis_tkeep,
  input  logic [S_COUNT-1:0]               s_eth_payload_axis_tvalid,
  output logic [S_COUNT-1:0]               s_eth_payload_axis_tready,
  input  logic [S_COUNT-1:0]               s_eth_payload_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]    s_eth_payload_axis_tuser,

  input  logic [S_COUNT*WEIGHT_WIDTH-1:0]  cfg_weight,

  output logic                             m_eth_hdr_valid,
  input  logic                             m_eth_hdr_ready,
  output logic [47:0]                      m_eth_dest_mac,
  output logic [47:0]                      m_eth_src_mac,
  output logic [15:0]                      m_eth_type,
  output logic [DATA_WIDTH-1:0]            m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_eth_payload_axis_tkeep,
  output logic                             m_eth_payload_axis_tvalid,
  input  logic                             m_eth_payload_axis_tready,
  output logic                             m_eth_payload_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_eth_payload_axis_tuser,

  output logic                             busy,
  output logic [$clog2(S_COUNT)-1:0]       grant_index
`ifdef ETH_ARB_MUX_WRR_STATS_EN
  ,
  output logic [S_COUNT*CNT_WIDTH-1:0]     stat_frame_count
`endif
);

  localparam int CL = $clog2(S_COUNT);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [CL-1:0]           last_q, last_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic                    hdr_valid_q, hdr_valid_d;
  logic [47:0]             dest_q, dest_d;
  logic [47:0]             src_q, src_d;
  logic [15:0]             type_q, type_d;

  // Skid buffer: output stage and temporary stage
  logic                    tready_int_q;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [KEEP_WIDTH-1:0]   out_keep_q, out_keep_d;
  logic                    out_last_q, out_last_d;
  logic [USER_WIDTH-1:0]   out_user_q, out_user_d;
  logic                    temp_valid_q, temp_valid_d;
  logic [DATA_WIDTH-1:0]   temp_data_q, temp_data_d;
  logic [KEEP_WIDTH-1:0]   temp_keep_q, temp_keep_d;
  logic                    temp_last_q, temp_last_d;
  logic [USER_WIDTH-1:0]   temp_user_q, temp_user_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                    sel_found_s;
  logic                    sel_same_s;
  logic [CL-1:0]           sel_idx_s;
  logic [CL-1:0]           cand_s;
  logic                    hdr_accept_s;
  logic [WEIGHT_WIDTH-1:0] sel_weight_s;
  logic [WEIGHT_WIDTH-1:0] new_credit_s;

  logic [DATA_WIDTH-1:0]   in_data_s;
  logic [KEEP_WIDTH-1:0]   in_keep_s;
  logic                    in_valid_s;
  logic                    in_last_s;
  logic [USER_WIDTH-1:0]   in_user_s;
  logic                    in_xfer_s;
  logic                    tready_early_s;

  // Arbitration: the last winner keeps the grant while it requests and has
  // credit left; otherwise search upward from last+1. The search ends on the
  // last winner itself, so a lone requester with exhausted credit is re-granted
  // as a fresh grant (credit reloaded) instead of stalling.
  always_comb begin
    sel_found_s = 1'b0;
    sel_same_s  = 1'b0;
    sel_idx_s   = last_q;
    cand_s      = last_q;
    if (s_eth_hdr_valid[last_q] && (credit_q != {WEIGHT_WIDTH{1'b0}})) begin
      sel_found_s = 1'b1;
      sel_same_s  = 1'b1;
    end else begin
      for (int i = 1; i <= S_COUNT; i++) begin
        cand_s = CL'((int'(last_q) + i) % S_COUNT);
        if (!sel_found_s && s_eth_hdr_valid[cand_s]) begin
          sel_found_s = 1'b1;
          sel_idx_s   = cand_s;
        end else begin
          sel_found_s = sel_found_s;
        end
      end
    end
  end

  // A header may only be taken while the output header register is free or
  // draining this cycle.
  assign hdr_accept_s = (state_q == ST_IDLE) && sel_found_s &&
                        (!hdr_valid_q || m_eth_hdr_ready);

  assign sel_weight_s = cfg_weight[int'(sel_idx_s)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign new_credit_s = (sel_weight_s == {WEIGHT_WIDTH{1'b0}}) ?
                        {WEIGHT_WIDTH{1'b0}} : (sel_weight_s - WEIGHT_WIDTH'(1));

  // Payload source is the granted port
  assign in_data_s  = s_eth_payload_axis_tdata[int'(last_q)*DATA_WIDTH +: DATA_WIDTH];
  assign in_keep_s  = s_eth_payload_axis_tkeep[int'(last_q)*KEEP_WIDTH +: KEEP_WIDTH];
  assign in_valid_s = s_eth_payload_axis_tvalid[last_q];
  assign in_last_s  = s_eth_payload_axis_tlast[last_q];
  assign in_user_s  = s_eth_payload_axis_tuser[int'(last_q)*USER_WIDTH +: USER_WIDTH];
  assign in_xfer_s  = (state_q == ST_PAYLOAD) && tready_int_q && in_valid_s;

  // Ready may be offered next cycle if the output drains now, or if the
  // temp slot is empty and at most one stage fills this cycle.
  assign tready_early_s = m_eth_payload_axis_tready ||
                          (!temp_valid_q && (!out_valid_q || !in_xfer_s));

  // Header handshake back to the winning source; held low during reset.
  always_comb begin
    s_eth_hdr_ready = {S_COUNT{1'b0}};
    if (hdr_accept_s && !rst) begin
      s_eth_hdr_ready[sel_idx_s] = 1'b1;
    end else begin
      s_eth_hdr_ready = {S_COUNT{1'b0}};
    end
  end

  // Payload ready goes only to the granted port, and only in PAYLOAD.
  always_comb begin
    s_eth_payload_axis_tready = {S_COUNT{1'b0}};
    if ((state_q == ST_PAYLOAD) && !rst) begin
      s_eth_payload_axis_tready[last_q] = tready_int_q;
    end else begin
      s_eth_payload_axis_tready = {S_COUNT{1'b0}};
    end
  end

  // FSM next state, grant/credit bookkeeping and output header register.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    credit_d    = credit_q;
    hdr_valid_d = hdr_valid_q && !m_eth_hdr_ready;
    dest_d      = dest_q;
    src_d       = src_q;
    type_d      = type_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_accept_s) begin
          state_d     = ST_PAYLOAD;
          last_d      = sel_idx_s;
          credit_d    = sel_same_s ? (credit_q - WEIGHT_WIDTH'(1)) : new_credit_s;
          hdr_valid_d = 1'b1;
          dest_d      = s_eth_dest_mac[int'(sel_idx_s)*48 +: 48];
          src_d       = s_eth_src_mac[int'(sel_idx_s)*48 +: 48];
          type_d      = s_eth_type[int'(sel_idx_s)*16 +: 16];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (in_xfer_s && in_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Skid buffer next state: fill output directly when it can move, park the
  // beat in temp when output is stalled, refill output from temp afterwards.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    out_user_d   = out_user_q;
    temp_valid_d = temp_valid_q;
    temp_data_d  = temp_data_q;
    temp_keep_d  = temp_keep_q;
    temp_last_d  = temp_last_q;
    temp_user_d  = temp_user_q;
    if (tready_int_q) begin
      if (m_eth_payload_axis_tready || !out_valid_q) begin
        out_valid_d = in_xfer_s;
        out_data_d  = in_data_s;
        out_keep_d  = in_keep_s;
        out_last_d  = in_last_s;
        out_user_d  = in_user_s;
      end else begin
        temp_valid_d = in_xfer_s;
        temp_data_d  = in_data_s;
        temp_keep_d  = in_keep_s;
        temp_last_d  = in_last_s;
        temp_user_d  = in_user_s;
      end
    end else if (m_eth_payload_axis_tready) begin
      out_valid_d  = temp_valid_q;
      out_data_d   = temp_data_q;
      out_keep_d   = temp_keep_q;
      out_last_d   = temp_last_q;
      out_user_d   = temp_user_q;
      temp_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= CL'(S_COUNT - 1);
      credit_q     <= {WEIGHT_WIDTH{1'b0}};
      hdr_valid_q  <= 1'b0;
      dest_q       <= 48'h0;
      src_q        <= 48'h0;
      type_q       <= 16'h0;
      tready_int_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {DATA_WIDTH{1'b0}};
      out_keep_q   <= {KEEP_WIDTH{1'b0}};
      out_last_q   <= 1'b0;
      out_user_q   <= {USER_WIDTH{1'b0}};
      temp_valid_q <= 1'b0;
      temp_data_q  <= {DATA_WIDTH{1'b0}};
      temp_keep_q  <= {KEEP_WIDTH{1'b0}};
      temp_last_q  <= 1'b0;
      temp_user_q  <= {USER_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      credit_q     <= credit_d;
      hdr_valid_q  <= hdr_valid_d;
      dest_q       <= dest_d;
      src_q        <= src_d;
      type_q       <= type_d;
      tready_int_q <= tready_early_s;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      out_user_q   <= out_user_d;
      temp_valid_q <= temp_valid_d;
      temp_data_q  <= temp_data_d;
      temp_keep_q  <= temp_keep_d;
      temp_last_q  <= temp_last_d;
      temp_user_q  <= temp_user_d;
    end
  end

  assign m_eth_hdr_valid           = hdr_valid_q;
  assign m_eth_dest_mac            = dest_q;
  assign m_eth_src_mac             = src_q;
  assign m_eth_type                = type_q;
  assign m_eth_payload_axis_tvalid = out_valid_q;
  assign m_eth_payload_axis_tdata  = out_data_q;
  assign m_eth_payload_axis_tkeep  = KEEP_ENABLE ? out_keep_q : {KEEP_WIDTH{1'b1}};
  assign m_eth_payload_axis_tlast  = out_last_q;
  assign m_eth_payload_axis_tuser  = out_user_q;
  assign busy                      = (state_q == ST_PAYLOAD);
  assign grant_index               = last_q;

`ifdef ETH_ARB_MUX_WRR_STATS_EN
  logic [CNT_WIDTH-1:0] frame_cnt_q [S_COUNT];

  // Per-port completed-frame counters, wrapping naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < S_COUNT; i++) begin
        frame_cnt_q[i] <= {CNT_WIDTH{1'b0}};
      end
    end else if (in_xfer_s && in_last_s) begin
      frame_cnt_q[last_q] <= frame_cnt_q[last_q] + CNT_WIDTH'(1);
    end else begin
      frame_cnt_q[last_q] <= frame_cnt_q[last_q];
    end
  end

  for (genvar g = 0; g < S_COUNT; g++) begin : g_stat
    assign stat_frame_count[g*CNT_WIDTH +: CNT_WIDTH] = frame_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_eth_arb_mux_wrr.sv
// -----------------------------------------------------------------------------
// Directed testbench for eth_arb_mux_wrr (S_COUNT=4, DATA_WIDTH=8).
// Per-port source models present frames whose beat data is {port, beat[5:0]};
// a scoreboard matches output headers/beats against accepted input ones, and
// grant orders are compared with hand-computed sequences.
// -----------------------------------------------------------------------------
module tb_eth_arb_mux_wrr;

  localparam int S_COUNT = 4;
  localparam int DW      = 8;
  localparam int KW      = 1;
  localparam int UW      = 1;
  localparam int WW      = 4;
`ifdef ETH_ARB_MUX_WRR_STATS_EN
  localparam int CW      = 2;
`else
  localparam int CW      = 16;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [S_COUNT-1:0]     s_eth_hdr_valid;
  logic [S_COUNT-1:0]     s_eth_hdr_ready;
  logic [S_COUNT*48-1:0]  s_eth_dest_mac;
  logic [S_COUNT*48-1:0]  s_eth_src_mac;
  logic [S_COUNT*16-1:0]  s_eth_type;
  logic [S_COUNT*DW-1:0]  s_tdata;
  logic [S_COUNT*KW-1:0]  s_tkeep;
  logic [S_COUNT-1:0]     s_tvalid;
  logic [S_COUNT-1:0]     s_tready;
  logic [S_COUNT-1:0]     s_tlast;
  logic [S_COUNT*UW-1:0]  s_tuser;
  logic [S_COUNT*WW-1:0]  cfg_weight;
  logic                   m_eth_hdr_valid;
  logic                   m_eth_hdr_ready;
  logic [47:0]            m_eth_dest_mac;
  logic [47:0]            m_eth_src_mac;
  logic [15:0]            m_eth_type;
  logic [DW-1:0]          m_tdata;
  logic [KW-1:0]          m_tkeep;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;
  logic [UW-1:0]          m_tuser;
  logic                   busy;
  logic [1:0]             grant_index;
`ifdef ETH_ARB_MUX_WRR_STATS_EN
  logic [S_COUNT*CW-1:0]  stat_frame_count;
`endif

  eth_arb_mux_wrr #(
    .S_COUNT(S_COUNT), .DATA_WIDTH(DW), .KEEP_ENABLE(1'b0), .KEEP_WIDTH(KW),
    .USER_WIDTH(UW), .WEIGHT_WIDTH(WW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac),
    .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .cfg_weight(cfg_weight),
    .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac),
    .m_eth_type(m_eth_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
    .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
    .busy(busy), .grant_index(grant_index)
`ifdef ETH_ARB_MUX_WRR_STATS_EN
    , .stat_frame_count(stat_frame_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // source models
  int   frames_left [S_COUNT];
  int   len         [S_COUNT];
  int   beat        [S_COUNT];
  logic in_pay      [S_COUNT];
  int   ready_cnt   [S_COUNT];
  int   hdr_rdy_cnt [S_COUNT];
  int   src_beats   [S_COUNT];
  logic tready_toggle;

  // scoreboard
  int          grant_log [$];
  logic [15:0] exp_type  [$];
  logic [8:0]  exp_beat  [$];
  int          out_beats;
  logic [8:0]  last_beat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    for (int p = 0; p < S_COUNT; p++) begin
      s_eth_hdr_valid[p]       = !in_pay[p] && (frames_left[p] > 0);
      s_eth_dest_mac[p*48 +: 48] = 48'h0200_0000_0000 + 48'(p);
      s_eth_src_mac[p*48 +: 48]  = 48'h0600_0000_0000 + 48'(p);
      s_eth_type[p*16 +: 16]   = 16'h8800 + 16'(p);
      s_tvalid[p]              = in_pay[p];
      s_tdata[p*DW +: DW]      = 8'((p << 6) | (beat[p] & 63));
      s_tlast[p]               = in_pay[p] && (beat[p] == len[p] - 1);
      s_tkeep[p]               = 1'b1;
      s_tuser[p]               = 1'b0;
    end
  endtask

  task automatic clear_tb_state();
    for (int p = 0; p < S_COUNT; p++) begin
      frames_left[p] = 0; len[p] = 1; beat[p] = 0; in_pay[p] = 1'b0;
      ready_cnt[p] = 0; hdr_rdy_cnt[p] = 0; src_beats[p] = 0;
    end
    grant_log.delete(); exp_type.delete(); exp_beat.delete();
    out_beats = 0; last_beat = 9'h0;
    tready_toggle = 1'b0; m_tready = 1'b1; m_eth_hdr_ready = 1'b1;
    drive_src();
  endtask

  // One clock: observe handshakes at negedge, update sources after posedge.
  task automatic tick();
    logic hf [S_COUNT];
    logic pf [S_COUNT];
    @(negedge clk);
    for (int p = 0; p < S_COUNT; p++) begin
      hf[p] = s_eth_hdr_valid[p] && s_eth_hdr_ready[p];
      pf[p] = s_tvalid[p] && s_tready[p];
      if (hf[p]) begin
        grant_log.push_back(p);
        exp_type.push_back(16'h8800 + 16'(p));
      end
      if (pf[p]) begin
        exp_beat.push_back({s_tlast[p], s_tdata[p*DW +: DW]});
        src_beats[p]++;
      end
      if (s_tready[p]) ready_cnt[p]++;
      if (s_eth_hdr_ready[p]) hdr_rdy_cnt[p]++;
    end
    if (m_eth_hdr_valid && m_eth_hdr_ready) begin
      if (exp_type.size() == 0) check_eq("hdr_unexpected", 64'd1, 64'd0);
      else check_eq("hdr_type", m_eth_type, exp_type.pop_front());
    end
    if (m_tvalid && m_tready) begin
      out_beats++;
      last_beat = {m_tlast, m_tdata};
      if (exp_beat.size() == 0) check_eq("beat_unexpected", 64'd1, 64'd0);
      else check_eq("beat", {m_tlast, m_tdata}, exp_beat.pop_front());
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < S_COUNT; p++) begin
      if (hf[p]) begin
        in_pay[p] = 1'b1; beat[p] = 0; frames_left[p]--;
      end else if (pf[p]) begin
        if (beat[p] == len[p] - 1) in_pay[p] = 1'b0;
        else beat[p]++;
      end
    end
    if (tready_toggle) m_tready = ~m_tready;
    drive_src();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_tb_state();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_grants(input int n, input int bound);
    for (int c = 0; c < bound && grant_log.size() < n; c++) tick();
    if (grant_log.size() < n) check_eq("grant_timeout", grant_log.size(), n);
  endtask

  task automatic wait_idle(input int bound);
    int pending;
    for (int c = 0; c < bound; c++) begin
      pending = 0;
      for (int p = 0; p < S_COUNT; p++)
        if (frames_left[p] > 0 || in_pay[p]) pending = 1;
      if (pending == 0) break;
      tick();
    end
    if (pending != 0) check_eq("idle_timeout", 64'd0, 64'd1);
    repeat (4) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_hdr_valid"}, m_eth_hdr_valid, 64'd0);
    check_eq({tag, "_dest"},      m_eth_dest_mac, 64'd0);
    check_eq({tag, "_type"},      m_eth_type, 64'd0);
    check_eq({tag, "_tvalid"},    m_tvalid, 64'd0);
    check_eq({tag, "_tdata"},     m_tdata, 64'd0);
    check_eq({tag, "_tlast"},     m_tlast, 64'd0);
    check_eq({tag, "_s_hdr_rdy"}, s_eth_hdr_ready, 64'd0);
    check_eq({tag, "_s_tready"},  s_tready, 64'd0);
    check_eq({tag, "_busy"},      busy, 64'd0);
  endtask

  initial begin
    int exp_a [8] = '{0, 0, 1, 2, 3, 0, 0, 1};
    int exp_b [4] = '{0, 1, 0, 1};

    // Reset state, with every port requesting so hdr_ready gating is visible
    rst = 1'b1;
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    clear_tb_state();
    for (int p = 0; p < S_COUNT; p++) frames_left[p] = 1;
    drive_src();
    #2;
    check_reset_outputs("rst_init");
    check_eq("rst_grant_index", grant_index, 64'd3);

    // Weighted round robin: weights 2,1,1,1
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd2};
    for (int p = 0; p < S_COUNT; p++) begin frames_left[p] = 1000; len[p] = 1; end
    drive_src();
    wait_grants(8, 300);
    for (int i = 0; i < 8; i++) check_eq("wrr_order", grant_log[i], exp_a[i]);
    check_eq("tkeep_ones", m_tkeep, 64'd1);

    // Weight 0 behaves as 1
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd0, 4'd1};
    frames_left[0] = 1000; frames_left[1] = 1000;
    drive_src();
    wait_grants(4, 200);
    for (int i = 0; i < 4; i++) check_eq("w0_order", grant_log[i], exp_b[i]);

    // 64-beat frame on port 2 with toggling m_tready
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    frames_left[2] = 1; len[2] = 64; tready_toggle = 1'b1;
    drive_src();
    wait_grants(1, 20);
    check_eq("c_busy_pay", busy, 64'd1);
    check_eq("c_grant_idx", grant_index, 64'd2);
    for (int c = 0; c < 1000 && out_beats < 64; c++) tick();
    repeat (4) tick();
    check_eq("c_beats", out_beats, 64'd64);
    check_eq("c_last_beat", last_beat, {1'b1, 8'hBF});
    check_eq("c_sb_empty", exp_beat.size(), 64'd0);
    check_eq("c_rdy_p0", ready_cnt[0], 64'd0);
    check_eq("c_rdy_p1", ready_cnt[1], 64'd0);
    check_eq("c_rdy_p3", ready_cnt[3], 64'd0);
    check_eq("c_busy_idle", busy, 64'd0);
    check_eq("c_grant_hold", grant_index, 64'd2);

    // Header back-pressure blocks the next header
    do_reset();
    m_eth_hdr_ready = 1'b0;
    frames_left[0] = 1; frames_left[1] = 1;
    drive_src();
    repeat (20) tick();
    check_eq("d_grants", grant_log.size(), 64'd1);
    check_eq("d_first", grant_log[0], 64'd0);
    check_eq("d_p1_req", s_eth_hdr_valid[1], 64'd1);
    check_eq("d_p1_rdy", hdr_rdy_cnt[1], 64'd0);
    check_eq("d_hdr_pend", m_eth_hdr_valid, 64'd1);
    check_eq("d_hdr_type", m_eth_type, 64'h8800);
    m_eth_hdr_ready = 1'b1;
    repeat (10) tick();
    check_eq("d_grants2", grant_log.size(), 64'd2);
    check_eq("d_second", grant_log[1], 64'd1);

    // Reset in the middle of a 40-beat frame on port 3
    do_reset();
    frames_left[3] = 1; len[3] = 40;
    drive_src();
    for (int c = 0; c < 200 && src_beats[3] < 10; c++) tick();
    check_eq("e_reached_b10", src_beats[3], 64'd10);
    check_eq("e_busy_mid", busy, 64'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("e_rst");
    clear_tb_state();
    frames_left[0] = 1; frames_left[3] = 1;
    drive_src();
    #1;
    check_eq("e_hdr_rdy_in_rst", s_eth_hdr_ready, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_grants(1, 20);
    check_eq("e_next_grant", grant_log[0], 64'd0);

`ifdef ETH_ARB_MUX_WRR_STATS_EN
    // Frame counters with CNT_WIDTH=2: port 0 sees 5 frames (wraps to 1)
    do_reset();
    frames_left[0] = 3; len[0] = 2; frames_left[3] = 1; len[3] = 2;
    drive_src();
    wait_idle(300);
    frames_left[0] = 2;
    drive_src();
    wait_idle(300);
    check_eq("f_cnt_p0", stat_frame_count[0*CW +: CW], 64'd1);
    check_eq("f_cnt_p1", stat_frame_count[1*CW +: CW], 64'd0);
    check_eq("f_cnt_p3", stat_frame_count[3*CW +: CW], 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eth_arb_mux_wrr.md
ETH_ARB_MUX_WRR -- requirements
Module: eth_arb_mux_wrr

Interface
REQ-001 SHALL provide parameters: S_COUNT, default 4, number of source ports (2..16).
REQ-002 SHALL provide parameters: DATA_WIDTH, default 8, payload width; KEEP_ENABLE, default (DATA_WIDTH>8), tkeep used; KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-003 SHALL provide parameters: USER_WIDTH, default 1, tuser width; WEIGHT_WIDTH, default 4, per-port weight width; CNT_WIDTH, default 16, statistics counter width.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: s_eth_hdr_valid/s_eth_hdr_ready  in/out  S_COUNT  per-port header handshake; s_eth_dest_mac, s_eth_src_mac  in  S_COUNT*48; s_eth_type  in  S_COUNT*16.
REQ-006 SHALL have ports: s_eth_payload_axis_tdata/tkeep/tvalid/tlast/tuser  in  S_COUNT*(DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH); s_eth_payload_axis_tready  out  S_COUNT.
REQ-007 SHALL have ports: cfg_weight  in  S_COUNT*WEIGHT_WIDTH  consecutive-frame quota per port.
REQ-008 SHALL have ports: m_eth_hdr_valid out 1, m_eth_hdr_ready in 1, m_eth_dest_mac/m_eth_src_mac out 48, m_eth_type out 16, m_eth_payload_axis_tdata/tkeep/tvalid/tlast/tuser out, m_eth_payload_axis_tready in 1.
REQ-009 SHALL have ports: busy  out  1  frame in progress; grant_index  out  $clog2(S_COUNT)  current/last granted port.

Function
REQ-010 SHALL run FSM states IDLE, PAYLOAD; arbitration and header acceptance occur only in IDLE.
REQ-011 In IDLE, SHALL select a port combinationally: last granted port if its hdr_valid is high and credit>0, else first requesting port searching from last+1 upward with wrap-around.
REQ-012 On a new grant SHALL load credit = max(weight,1)-1 (weight 0 treated as 1); on re-grant of same port SHALL decrement credit; cfg_weight sampled only at grant time.
REQ-013 SHALL assert s_eth_hdr_ready[g] in IDLE the same cycle as grant when m_eth_hdr_valid is low or m_eth_hdr_ready is high; header transfer moves FSM to PAYLOAD.
REQ-014 SHALL register header fields; m_eth_hdr_valid rises the cycle after transfer and holds until m_eth_hdr_ready; fields stable while valid.
REQ-015 In PAYLOAD SHALL drive s_eth_payload_axis_tready only on granted port, equal to internal registered ready; all other ports 0.
REQ-016 SHALL pass payload through a 2-entry skid buffer (output + temp registers); latency 1 cycle; no beat loss or duplication under any m_tready pattern; full throughput when m_tready held high.
REQ-017 Transfer of tlast on granted port SHALL return FSM to IDLE next cycle; new header acceptance possible that cycle (minimum one idle cycle between frames on the source side).
REQ-018 busy SHALL be high in PAYLOAD; grant_index SHALL hold the last granted port in IDLE.
REQ-019 Header of next frame SHALL NOT be accepted while previous m_eth_hdr_valid is pending without m_eth_hdr_ready.
REQ-020 m_eth_payload_axis_tkeep SHALL be all-ones when KEEP_ENABLE=0.

Reset
REQ-021 rst high SHALL immediately force: FSM IDLE, all valid/ready outputs 0, header and payload registers 0, credit 0, busy 0, last-grant pointer S_COUNT-1 (port 0 wins first), statistics 0.
REQ-022 rst asserted mid-frame SHALL discard the partial frame; after release arbitration restarts from port 0.

Configuration
REQ-023 With ETH_ARB_MUX_WRR_STATS_EN defined SHALL add output stat_frame_count  out  S_COUNT*CNT_WIDTH, per-port count of completed frames (tlast transfers), wrapping modulo 2^CNT_WIDTH.
REQ-024 Without ETH_ARB_MUX_WRR_STATS_EN the port and counters SHALL be absent; all other behaviour identical.

Verification
REQ-025 Ports 0..3 continuously request, weights 2,1,1,1, m ready always -> grant order 0,0,1,2,3,0,0,1...
REQ-026 Weight 0 on port 1, ports 0,1 requesting -> order 0,1,0,1 (weight 0 acts as 1).
REQ-027 Single 64-byte frame on port 2, m_tready toggling 1/0 every cycle -> 64 beats out in order, tlast on beat 64, no s_tready on ports 0,1,3.
REQ-028 m_eth_hdr_ready held low after first header, port 1 requesting -> s_eth_hdr_ready[1] stays 0 until m_eth_hdr_ready rises.
REQ-029 rst pulsed at beat 10 of a 40-byte frame -> all outputs 0 during reset; next grant is port 0 when ports 0 and 3 request.
REQ-030 STATS_EN, 3 frames port 0 and 1 frame port 3 with CNT_WIDTH=2, then 2 more port 0 frames -> counts port0=1 (wrapped), port3=1.
